// File: rtl/ram_1r1w_pipelined.sv
// 1-read/1-write RAM with lane masks, configurable read latency, read-during-write
// policy and a post-reset clear engine that zeroes the array one word per cycle.
module ram_1r1w_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int NUM_PARTITIONS = 4,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic                      wr_en,
  input  logic [NUM_PARTITIONS-1:0] wr_mask,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_en,
  input  logic [NUM_PARTITIONS-1:0] rd_mask,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      init_busy,
  output logic                      o_dbg_state
);
  localparam int PW = DATA_WIDTH / NUM_PARTITIONS;
  localparam logic [ADDR_WIDTH:0]   LP_SIZE = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(SIZE-1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
  localparam state_t LP_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  if (DATA_WIDTH % NUM_PARTITIONS != 0) begin : g_chk_width
    $error("ram_1r1w_pipelined: DATA_WIDTH must be divisible by NUM_PARTITIONS");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_latency
    $error("ram_1r1w_pipelined: RD_LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_clr_we;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_wr_lanes;
  logic [DATA_WIDTH-1:0] w_rd_lanes;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_masked;
  logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
  logic                  r_pipe_vld  [RD_LATENCY];

  // Clear FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LP_RST_STATE;
    else     r_state <= w_state_nxt;
  end

  // Clear FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == LP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    init_busy   = 1'b0;
    w_clr_we    = 1'b0;
    o_dbg_state = r_state;
    if (r_state == S_CLEAR) begin
      init_busy = 1'b1;
      w_clr_we  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cnt <= '0;
    else if (w_clr_we) r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
  end

  // Requests carry no ready: a request is taken on any edge where its enable is
  // high and init_busy is low; every taken read yields exactly one rd_valid pulse.
  assign w_wr_in_range = ({1'b0, wr_addr} < LP_SIZE);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_SIZE);
  assign w_wr_fire     = wr_en && !init_busy && w_wr_in_range;
  assign w_rd_fire     = rd_en && !init_busy;

  always_comb begin
    w_wr_lanes = '0;
    w_rd_lanes = '0;
    for (int j = 0; j < NUM_PARTITIONS; j++) begin
      w_wr_lanes[j*PW +: PW] = {PW{wr_mask[j]}};
      w_rd_lanes[j*PW +: PW] = {PW{rd_mask[j]}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int j = 0; j < NUM_PARTITIONS; j++)
        if (wr_mask[j]) r_mem[wr_addr][j*PW +: PW] <= wr_data[j*PW +: PW];
    end
  end

  // Write-first bypass merges only the lanes being written this cycle
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[rd_addr];
      if (RDW_MODE == 1 && w_wr_fire && (wr_addr == rd_addr))
        w_rd_word = (w_rd_word & ~w_wr_lanes) | (wr_data & w_wr_lanes);
    end
    w_rd_masked = w_rd_word & w_rd_lanes;
  end

  // Data registers load only with a valid so rd_data holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_pipe_data[s] <= '0;
        r_pipe_vld[s]  <= 1'b0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_fire;
      if (w_rd_fire) r_pipe_data[0] <= w_rd_masked;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        if (r_pipe_vld[s-1]) r_pipe_data[s] <= r_pipe_data[s-1];
      end
    end
  end

  assign rd_data  = r_pipe_data[RD_LATENCY-1];
  assign rd_valid = r_pipe_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_1r1w_pipelined.sv
// Bench for ram_1r1w_pipelined: two instances (16 words/latency 1/old-data and
// 12 words/latency 3/write-first) share one stimulus stream and a reference model.
module tb_ram_1r1w_pipelined;
  localparam int SZ  [2] = '{16, 12};
  localparam int LAT [2] = '{1, 3};
  localparam int RDW [2] = '{0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_data;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [3:0]  rd_mask;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_busy0, init_busy1;
  logic        dbg0, dbg1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [31:0] mem_m [2][16];
  int          since_rel [2];
  logic [31:0] last_d [2];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          due_q0[$];
  int          due_q1[$];

  ram_1r1w_pipelined #(.DATA_WIDTH(32), .SIZE(16), .NUM_PARTITIONS(4), .RD_LATENCY(1),
                       .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_mask(wr_mask), .rd_addr(rd_addr), .rd_en(rd_en), .rd_mask(rd_mask),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0), .o_dbg_state(dbg0));

  ram_1r1w_pipelined #(.DATA_WIDTH(32), .SIZE(12), .NUM_PARTITIONS(4), .RD_LATENCY(3),
                       .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_mask(wr_mask), .rd_addr(rd_addr), .rd_en(rd_en), .rd_mask(rd_mask),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1), .o_dbg_state(dbg1));

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int j = 0; j < 4; j++) if (m[j]) r[j*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    return (old_w & ~lanes(m)) | (new_w & lanes(m));
  endfunction

  // One rising edge as seen by the model, using the inputs held across that edge
  task automatic model_step();
    logic        busy;
    logic [31:0] d;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        since_rel[i] = 0;
        last_d[i]    = 32'h0;
        for (int a = 0; a < 16; a++) mem_m[i][a] = 32'h0;
      end
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      busy = (since_rel[i] < SZ[i]);
      if (!busy && rd_en) begin
        d = 32'h0;
        if (int'(rd_addr) < SZ[i]) begin
          d = mem_m[i][rd_addr];
          if (RDW[i] == 1 && wr_en && wr_addr == rd_addr) d = merge(d, wr_data, wr_mask);
        end
        d = d & lanes(rd_mask);
        if (i == 0) begin exp_q0.push_back(d); due_q0.push_back(cyc + LAT[0] - 1); end
        else        begin exp_q1.push_back(d); due_q1.push_back(cyc + LAT[1] - 1); end
      end
      if (!busy && wr_en && int'(wr_addr) < SZ[i])
        mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], wr_data, wr_mask);
      if (since_rel[i] < SZ[i]) since_rel[i]++;
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    check("busy0", init_busy0, since_rel[0] < SZ[0]);
    check("busy1", init_busy1, since_rel[1] < SZ[1]);
    exp_v = (due_q0.size() > 0) && (due_q0[0] == cyc);
    check("vld0", rd_valid0, exp_v);
    if (exp_v) begin last_d[0] = exp_q0.pop_front(); void'(due_q0.pop_front()); end
    check("data0", rd_data0, last_d[0]);
    exp_v = (due_q1.size() > 0) && (due_q1[0] == cyc);
    check("vld1", rd_valid1, exp_v);
    if (exp_v) begin last_d[1] = exp_q1.pop_front(); void'(due_q1.pop_front()); end
    check("data1", rd_data1, last_d[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wm, input logic re, input logic [3:0] ra,
                       input logic [3:0] rm);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_en = re; rd_addr = ra; rd_mask = rm;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 4'h0);
  endtask

  // Async reset must clear the read pipelines before any clock edge
  task automatic pulse_rst(input int hold);
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("rst_vld0", rd_valid0, 1'b0);
    check("rst_vld1", rd_valid1, 1'b0);
    check("rst_data0", rd_data0, 32'h0);
    check("rst_data1", rd_data1, 32'h0);
    check("rst_busy0", init_busy0, 1'b1);
    for (int k = 0; k < hold; k++) cycle();
    rst = 1'b0;
  endtask

  task automatic random_traffic(input int n);
    logic [3:0] wa;
    for (int k = 0; k < n; k++) begin
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0; wr_mask = 4'h0;
    rd_en = 1'b0; rd_addr = 4'h0; rd_mask = 4'h0;
    for (int i = 0; i < 2; i++) begin since_rel[i] = 0; last_d[i] = 32'h0; end
    for (int k = 0; k < 3; k++) cycle();
    rst = 1'b0;

    // requests while clearing must be ignored
    for (int k = 0; k < 20; k++) drive(1'b1, 4'h2, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'h2, 4'hF);
    for (int a = 0; a < 16; a++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a), 4'hF);
    idle(4);

    // masked write/read
    drive(1'b1, 4'h3, 32'hAABB_CCDD, 4'hF, 1'b0, 4'h0, 4'h0);
    drive(1'b1, 4'h3, 32'h1122_3344, 4'h5, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3, 4'hF);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3, 4'h3);
    idle(4);

    // consecutive reads and read-during-write
    for (int a = 0; a < 3; a++) drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a), 4'hF);
    idle(2);
    drive(1'b1, 4'h5, 32'h1234_5678, 4'hF, 1'b0, 4'h0, 4'h0);
    drive(1'b1, 4'h5, 32'hFFFF_FFFF, 4'h3, 1'b1, 4'h5, 4'hF);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5, 4'hF);
    idle(4);

    // out of range for the 12-word instance
    drive(1'b1, 4'hD, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'hD, 4'hF);
    drive(1'b1, 4'hB, 32'hCAFE_F00D, 4'hF, 1'b1, 4'hB, 4'hF);
    idle(4);

    random_traffic(400);

    // reset with reads in flight, then again mid-clear
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1, 4'hF);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h2, 4'hF);
    pulse_rst(1);
    idle(7);
    pulse_rst(2);
    random_traffic(300);
    idle(6);

    check("drain0", due_q0.size(), 32'h0);
    check("drain1", due_q1.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
